// File: rtl/alu_src_serializer.sv
// Serializes one captured wavefront operand set (NUM_SRC sources, vcc, exec) into
// ALU_LANES-wide lane groups, optionally skipping groups whose exec slice is all zero.
module alu_src_serializer #(
  parameter int NUM_SRC    = 3,
  parameter int LANE_W     = 32,
  parameter int WAVE_LANES = 64,
  parameter int ALU_LANES  = 16,
  parameter int SKIP_IDLE  = 1,
  localparam int GROUPS    = WAVE_LANES / ALU_LANES,
  localparam int GW        = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int IN_W      = NUM_SRC * WAVE_LANES * LANE_W,
  localparam int OUT_W     = NUM_SRC * ALU_LANES * LANE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic [WAVE_LANES-1:0] in_vcc,
  input  logic [WAVE_LANES-1:0] in_exec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [ALU_LANES-1:0]  out_vcc,
  output logic [ALU_LANES-1:0]  out_exec,
  output logic [GW-1:0]         out_group,
  output logic                  out_last
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state, state_next;

  logic [IN_W-1:0]       cap_data;
  logic [WAVE_LANES-1:0] cap_vcc;
  logic [WAVE_LANES-1:0] cap_exec;

  logic                  xfer_in;
  logic                  xfer_out;
  logic [GROUPS-1:0]     act_in;
  logic [GROUPS-1:0]     act_cap;
  logic [GW-1:0]         load_group;
  logic                  load_last;
  logic [GW-1:0]         adv_group;
  logic                  adv_last;

  // A group is eligible for issue if skipping is off or its exec slice has any lane set.
  function automatic logic [GROUPS-1:0] active_groups(input logic [WAVE_LANES-1:0] exec);
    logic [GROUPS-1:0] act;
    act = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      act[g] = (SKIP_IDLE == 0) || (|exec[g*ALU_LANES +: ALU_LANES]);
    end
    return act;
  endfunction

  function automatic logic has_from(input logic [GROUPS-1:0] act, input int unsigned start);
    logic found;
    found = 1'b0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      if (act[g] && g >= start) found = 1'b1;
    end
    return found;
  endfunction

  // Lowest eligible group at or above start; 0 when none exists.
  function automatic logic [GW-1:0] idx_from(input logic [GROUPS-1:0] act, input int unsigned start);
    logic [GW-1:0] idx;
    int unsigned   g;
    idx = '0;
    for (int unsigned n = 0; n < GROUPS; n++) begin
      g = GROUPS - 1 - n;
      if (act[g] && g >= start) idx = GW'(g);
    end
    return idx;
  endfunction

  function automatic logic [OUT_W-1:0] slice_data(input logic [IN_W-1:0] d, input logic [GW-1:0] grp);
    logic [OUT_W-1:0] o;
    int unsigned      gi;
    o  = '0;
    gi = int'(grp);
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      for (int unsigned j = 0; j < ALU_LANES; j++) begin
        o[(k*ALU_LANES + j)*LANE_W +: LANE_W] = d[(k*WAVE_LANES + gi*ALU_LANES + j)*LANE_W +: LANE_W];
      end
    end
    return o;
  endfunction

  function automatic logic [ALU_LANES-1:0] slice_mask(input logic [WAVE_LANES-1:0] m, input logic [GW-1:0] grp);
    int unsigned gi;
    gi = int'(grp);
    return m[gi*ALU_LANES +: ALU_LANES];
  endfunction

  assign out_valid = (state == ISSUE);
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_valid && out_ready;

  always_comb begin
    act_in     = active_groups(in_exec);
    act_cap    = active_groups(cap_exec);
    // An all-zero exec still issues group 0 as the single, final beat.
    load_group = idx_from(act_in, 0);
    load_last  = !has_from(act_in, int'(load_group) + 1);
    adv_group  = idx_from(act_cap, int'(out_group) + 1);
    adv_last   = !has_from(act_cap, int'(adv_group) + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ISSUE;
      end
      ISSUE: begin
        if (xfer_out && out_last) begin
          in_ready   = 1'b1;
          state_next = in_valid ? ISSUE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_data  <= '0;
      cap_vcc   <= '0;
      cap_exec  <= '0;
      out_data  <= '0;
      out_vcc   <= '0;
      out_exec  <= '0;
      out_group <= '0;
      out_last  <= 1'b0;
    end else if (xfer_in) begin
      cap_data  <= in_data;
      cap_vcc   <= in_vcc;
      cap_exec  <= in_exec;
      out_data  <= slice_data(in_data, load_group);
      out_vcc   <= slice_mask(in_vcc, load_group);
      out_exec  <= slice_mask(in_exec, load_group);
      out_group <= load_group;
      out_last  <= load_last;
    end else if (xfer_out && !out_last) begin
      out_data  <= slice_data(cap_data, adv_group);
      out_vcc   <= slice_mask(cap_vcc, adv_group);
      out_exec  <= slice_mask(cap_exec, adv_group);
      out_group <= adv_group;
      out_last  <= adv_last;
    end else if (xfer_out) begin
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_src_serializer.sv
// Directed bench: one serializer with SKIP_IDLE=0 and one with SKIP_IDLE=1, table vectors
// plus back-to-back, stall and mid-issue reset sequences.
module tb_alu_src_serializer;

  localparam int NS = 3, LW = 32, WL = 64, AL = 16, GW = 2;
  localparam int IN_W = NS*WL*LW, OUT_W = NS*AL*LW;
  localparam logic [63:0] VCC_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] VCC_B = 64'hFEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic [IN_W-1:0] in_data = '0;
  logic [WL-1:0]   in_vcc = '0, in_exec = '0;
  logic            out_ready = 1'b1;
  logic            sel = 1'b0;

  logic              ir0, ir1, ov0, ov1, ol0, ol1;
  logic [OUT_W-1:0]  od0, od1;
  logic [AL-1:0]     ovcc0, ovcc1, oex0, oex1;
  logic [GW-1:0]     og0, og1;

  logic              o_ready_in, o_valid, o_last;
  logic [OUT_W-1:0]  o_data;
  logic [AL-1:0]     o_vcc, o_exec;
  logic [GW-1:0]     o_group;

  int n_total = 0;
  int n_pass  = 0;

  alu_src_serializer #(.NUM_SRC(NS), .LANE_W(LW), .WAVE_LANES(WL), .ALU_LANES(AL), .SKIP_IDLE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(ir0), .in_data(in_data),
    .in_vcc(in_vcc), .in_exec(in_exec), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_vcc(ovcc0), .out_exec(oex0), .out_group(og0), .out_last(ol0));

  alu_src_serializer #(.NUM_SRC(NS), .LANE_W(LW), .WAVE_LANES(WL), .ALU_LANES(AL), .SKIP_IDLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(ir1), .in_data(in_data),
    .in_vcc(in_vcc), .in_exec(in_exec), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_vcc(ovcc1), .out_exec(oex1), .out_group(og1), .out_last(ol1));

  assign o_ready_in = sel ? ir1   : ir0;
  assign o_valid    = sel ? ov1   : ov0;
  assign o_last     = sel ? ol1   : ol0;
  assign o_data     = sel ? od1   : od0;
  assign o_vcc      = sel ? ovcc1 : ovcc0;
  assign o_exec     = sel ? oex1  : oex0;
  assign o_group    = sel ? og1   : og0;

  always #5 clk = ~clk;

  typedef struct {
    logic        skip;
    logic [63:0] exec;
    int          nbeats;
    logic [3:0][1:0] grp;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic check_data(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else begin
      for (int l = 0; l < NS*AL; l++) begin
        if (act[l*LW +: LW] !== exp[l*LW +: LW]) begin
          $display("FAIL %s: lane %0d actual=%h required=%h", name, l, act[l*LW +: LW], exp[l*LW +: LW]);
          break;
        end
      end
    end
  endtask

  task automatic fill_data(input logic [31:0] offset);
    for (int k = 0; k < NS; k++)
      for (int i = 0; i < WL; i++)
        in_data[(k*WL + i)*LW +: LW] = offset + 32'(k*256 + i);
  endtask

  function automatic logic [OUT_W-1:0] exp_data(input int g, input logic [31:0] offset);
    logic [OUT_W-1:0] e;
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < AL; j++)
        e[(k*AL + j)*LW +: LW] = offset + 32'(k*256 + g*AL + j);
    return e;
  endfunction

  task automatic check_beat(input string tag, input int g, input logic last, input logic [31:0] off,
                            input logic [63:0] vcc, input logic [63:0] exec);
    check({tag, "_valid"}, 64'(o_valid), 64'd1);
    check({tag, "_group"}, 64'(o_group), 64'(g));
    check({tag, "_last"},  64'(o_last),  64'(last));
    check({tag, "_vcc"},   64'(o_vcc),   64'(vcc[g*AL +: AL]));
    check({tag, "_exec"},  64'(o_exec),  64'(exec[g*AL +: AL]));
    check_data({tag, "_data"}, o_data, exp_data(g, off));
  endtask

  task automatic apply_vector(input int idx, input vec_t v);
    string tag;
    sel = v.skip;
    in_exec = v.exec;
    in_vcc = VCC_A;
    fill_data(32'(idx) << 20);
    @(negedge clk);
    tag = $sformatf("vec%0d", idx);
    check({tag, "_in_ready_idle"}, 64'(o_ready_in), 64'd1);
    if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    for (int b = 0; b < v.nbeats; b++) begin
      check_beat($sformatf("vec%0d_b%0d", idx, b), int'(v.grp[b]), logic'(b == v.nbeats-1),
                 32'(idx) << 20, VCC_A, v.exec);
      @(negedge clk);
    end
    check({tag, "_done_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_done_in_ready"}, 64'(o_ready_in), 64'd1);
  endtask

  initial begin
    tbl[0] = '{skip: 1'b0, exec: 64'hFFFF_FFFF_FFFF_FFFF, nbeats: 4, grp: {2'd3, 2'd2, 2'd1, 2'd0}};
    tbl[1] = '{skip: 1'b1, exec: 64'h0000_FFFF_0000_000F, nbeats: 2, grp: {2'd0, 2'd0, 2'd2, 2'd0}};
    tbl[2] = '{skip: 1'b1, exec: 64'h0000_0000_0000_0000, nbeats: 1, grp: {2'd0, 2'd0, 2'd0, 2'd0}};
    tbl[3] = '{skip: 1'b1, exec: 64'hFFFF_0000_0000_0000, nbeats: 1, grp: {2'd0, 2'd0, 2'd0, 2'd3}};
    tbl[4] = '{skip: 1'b1, exec: 64'hFFFF_FFFF_FFFF_FFFF, nbeats: 4, grp: {2'd3, 2'd2, 2'd1, 2'd0}};
    tbl[5] = '{skip: 1'b0, exec: 64'h0000_0000_0000_0000, nbeats: 4, grp: {2'd3, 2'd2, 2'd1, 2'd0}};
    tbl[6] = '{skip: 1'b1, exec: 64'h0001_0000_8000_0000, nbeats: 2, grp: {2'd0, 2'd0, 2'd3, 2'd1}};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_in_ready", 64'(o_ready_in), 64'd0);
    check("rst_group", 64'(o_group), 64'd0);
    check("rst_last", 64'(o_last), 64'd0);
    check_data("rst_data", o_data, '0);
    check("rst_vcc_exec", {32'(o_vcc), 32'(o_exec)}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) apply_vector(i, tbl[i]);

    // Back-to-back: two sets with in_valid held, 8 beats with no bubble
    sel = 1'b0;
    in_exec = '1;
    in_vcc = VCC_A;
    fill_data(32'h0000_0000);
    @(negedge clk);
    in_valid0 = 1'b1;
    @(negedge clk);
    fill_data(32'h1000_0000);
    in_vcc = VCC_B;
    for (int b = 0; b < 8; b++) begin
      if (b == 4) in_valid0 = 1'b0;
      check_beat($sformatf("b2b_b%0d", b), b % 4, logic'(b % 4 == 3),
                 (b < 4) ? 32'h0 : 32'h1000_0000, (b < 4) ? VCC_A : VCC_B, 64'hFFFF_FFFF_FFFF_FFFF);
      check($sformatf("b2b_in_ready_b%0d", b), 64'(o_ready_in), 64'(b % 4 == 3));
      @(negedge clk);
    end
    check("b2b_done_valid", 64'(o_valid), 64'd0);

    // Stall on group 1 for three cycles
    fill_data(32'h2000_0000);
    in_vcc = VCC_A;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    check_beat("stall_g0", 0, 1'b0, 32'h2000_0000, VCC_A, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check_beat("stall_g1", 1, 1'b0, 32'h2000_0000, VCC_A, 64'hFFFF_FFFF_FFFF_FFFF);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_beat($sformatf("stall_hold%0d", c), 1, 1'b0, 32'h2000_0000, VCC_A, 64'hFFFF_FFFF_FFFF_FFFF);
      check($sformatf("stall_in_ready%0d", c), 64'(o_ready_in), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_beat("stall_g2", 2, 1'b0, 32'h2000_0000, VCC_A, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check_beat("stall_g3", 3, 1'b1, 32'h2000_0000, VCC_A, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("stall_done_valid", 64'(o_valid), 64'd0);

    // Reset during group 1 aborts the set
    fill_data(32'h3000_0000);
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    @(negedge clk);
    check("mrst_pre_group", 64'(o_group), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_valid", 64'(o_valid), 64'd0);
    check("mrst_in_ready", 64'(o_ready_in), 64'd0);
    check("mrst_group_last", {32'(o_group), 32'(o_last)}, 64'd0);
    check_data("mrst_data", o_data, '0);
    check("mrst_exec", 64'(o_exec), 64'd0);
    rst = 1'b0;
    #1;
    check("mrst_in_ready_after", 64'(o_ready_in), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mrst_no_beat%0d", c), 64'(o_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
